// File: rtl/alu_a_seq.sv
// Multi-cycle sequencer for ALU operand-A selection and datapath strobes.
// Optional WAIT-state watchdog is enabled by defining ALU_A_SEQ_TIMEOUT_EN.
module alu_a_seq #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] instr_class,
   input  logic       mdu_done,
   output logic [2:0] muxt_alu_a,
   output logic       ir_we,
   output logic       pc_we,
   output logic       mdu_start,
   output logic       rf_we,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WAIT   = 3'd4,
      WB     = 3'd5
   } state_t;

   localparam logic [2:0] SEL_RS    = 3'd0;
   localparam logic [2:0] SEL_PC    = 3'd1;
   localparam logic [2:0] SEL_EXT5  = 3'd2;
   localparam logic [2:0] SEL_CONST = 3'd3;
   localparam logic [2:0] SEL_NONE  = 3'd7;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] cls_q;
   logic       err_q;
   logic       err_nxt;
   logic       timeout;

`ifdef ALU_A_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Counter reads k-1 during the k-th WAIT cycle, so the limit fires on cycle TIMEOUT_CYC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   assign timeout = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cls_q <= 3'd0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
         if (state == IDLE && start) begin
            cls_q <= instr_class;
         end
      end
   end

   // mdu_done has priority over the watchdog in the same WAIT cycle.
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      case (state)
         IDLE:   if (start) state_nxt = FETCH;
         FETCH:  state_nxt = DECODE;
         DECODE: begin
            if (cls_q >= 3'd6) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else begin
               state_nxt = EXEC;
            end
         end
         EXEC:   state_nxt = (cls_q == 3'd4) ? WAIT : WB;
         WAIT: begin
            if (mdu_done) begin
               state_nxt = WB;
            end else if (timeout) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      muxt_alu_a = SEL_NONE;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      mdu_start  = 1'b0;
      rf_we      = 1'b0;
      done       = 1'b0;
      case (state)
         FETCH: begin
            muxt_alu_a = SEL_PC;
            ir_we      = 1'b1;
            pc_we      = 1'b1;
         end
         DECODE: muxt_alu_a = SEL_PC;
         EXEC: begin
            case (cls_q)
               3'd0, 3'd2: muxt_alu_a = SEL_RS;
               3'd1:       muxt_alu_a = SEL_EXT5;
               3'd3: begin
                  muxt_alu_a = SEL_PC;
                  pc_we      = 1'b1;
               end
               3'd4: begin
                  muxt_alu_a = SEL_RS;
                  mdu_start  = 1'b1;
               end
               3'd5:       muxt_alu_a = SEL_CONST;
               default:    muxt_alu_a = SEL_NONE;
            endcase
         end
         WB: begin
            done  = 1'b1;
            rf_we = (cls_q != 3'd2);
         end
         default: muxt_alu_a = SEL_NONE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign err     = err_q;
   assign state_o = state;

endmodule

// File: tb/tb_alu_a_seq.sv
// Randomized scoreboard bench for alu_a_seq; timeout cases build only when
// ALU_A_SEQ_TIMEOUT_EN is defined (instantiated with TIMEOUT_CYC=8).
module tb_alu_a_seq;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] instr_class;
   logic       mdu_done;
   logic [2:0] muxt_alu_a;
   logic       ir_we, pc_we, mdu_start, rf_we, busy, done, err;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int is_err;
      int lat;
      int mux_seq;
      int late_mux;
      int pc_cnt;
      int ir_cnt;
      int mdu_cnt;
      int rf_cnt;
      int busy_cnt;
   } resp_t;

   resp_t sb[$];

   alu_a_seq #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .instr_class(instr_class),
      .mdu_done(mdu_done), .muxt_alu_a(muxt_alu_a), .ir_we(ir_we),
      .pc_we(pc_we), .mdu_start(mdu_start), .rf_we(rf_we), .busy(busy),
      .done(done), .err(err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: cycle 1 is FETCH; the response cycle carries done or err.
   function automatic resp_t model_expect(input int cls, input int d);
      resp_t r;
      int    sel;
      case (cls)
         1:       sel = 2;
         3:       sel = 1;
         5:       sel = 3;
         default: sel = 0;
      endcase
      r.late_mux = 0;
      r.ir_cnt   = 1;
      r.pc_cnt   = 1 + ((cls == 3) ? 1 : 0);
      r.mdu_cnt  = (cls == 4) ? 1 : 0;
      if (cls >= 6) begin
         r.is_err   = 1;
         r.lat      = 3;
         r.mux_seq  = (1 << 6) | (1 << 3) | 7;
         r.rf_cnt   = 0;
         r.busy_cnt = 2;
         return r;
      end
      r.mux_seq = (1 << 6) | (1 << 3) | sel;
      r.is_err  = 0;
      r.lat     = (cls == 4) ? 4 + d : 4;
      r.rf_cnt  = (cls == 2) ? 0 : 1;
`ifdef ALU_A_SEQ_TIMEOUT_EN
      if (cls == 4 && d > TO) begin
         r.is_err = 1;
         r.lat    = 4 + TO;
         r.rf_cnt = 0;
      end
`endif
      r.busy_cnt = r.is_err ? r.lat - 1 : r.lat;
      return r;
   endfunction

   // d selects the WAIT cycle carrying mdu_done; beyond the watchdog limit it never arrives.
   task automatic applyStimulus(input int cls, input int d);
      resp_t exp_r;
      exp_r = model_expect(cls, d);
      sb.push_back(exp_r);
      @(negedge clk);
      start       = 1'b1;
      instr_class = 3'(cls);
      mdu_done    = 1'($urandom_range(0, 1));
      for (int k = 1; k <= exp_r.lat; k++) begin
         @(negedge clk);
         start       = (k < exp_r.lat) ? 1'($urandom_range(0, 1)) : 1'b0;
         instr_class = 3'($urandom_range(0, 7));
         if (cls != 4 || k <= 3) begin
            mdu_done = 1'($urandom_range(0, 1));
         end else begin
`ifdef ALU_A_SEQ_TIMEOUT_EN
            mdu_done = (k == 3 + d) && (d <= TO);
`else
            mdu_done = (k == 3 + d);
`endif
         end
      end
      @(negedge clk);
      start    = 1'b0;
      mdu_done = 1'b0;
   endtask

   // Monitor: accumulates one transaction from busy rising to done/err, then scores it.
   initial begin : monitor
      bit    in_txn = 0;
      int    c = 0;
      int    mux_seq = 0, late = 0, pc_c = 0, ir_c = 0, mdu_c = 0, rf_c = 0, busy_c = 0;
      resp_t e;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            in_txn = 0;
            continue;
         end
         if (!in_txn && busy) begin
            in_txn = 1;
            c = 0; mux_seq = 0; late = 0; pc_c = 0; ir_c = 0;
            mdu_c = 0; rf_c = 0; busy_c = 0;
         end
         if (!in_txn) begin
            if (done || err) checkOutput("stray_resp", {30'd0, done, err}, 32'd0);
            continue;
         end
         c++;
         if (c <= 3) mux_seq = (mux_seq << 3) | int'(muxt_alu_a);
         else if (muxt_alu_a != 3'd7) late++;
         pc_c   += int'(pc_we);
         ir_c   += int'(ir_we);
         mdu_c  += int'(mdu_start);
         rf_c   += int'(rf_we);
         busy_c += int'(busy);
         if (done || err) begin
            in_txn = 0;
            checkOutput("done_err_excl", {31'd0, done & err}, 32'd0);
            if (sb.size() != 1) begin
               checkOutput("sb_depth", sb.size(), 32'd1);
            end else begin
               e = sb.pop_front();
               checkOutput("resp_is_err", {31'd0, err}, e.is_err);
               checkOutput("latency",     c,            e.lat);
               checkOutput("mux_seq",     mux_seq,      e.mux_seq);
               checkOutput("late_mux",    late,         e.late_mux);
               checkOutput("pc_we_cnt",   pc_c,         e.pc_cnt);
               checkOutput("ir_we_cnt",   ir_c,         e.ir_cnt);
               checkOutput("mdu_st_cnt",  mdu_c,        e.mdu_cnt);
               checkOutput("rf_we_cnt",   rf_c,         e.rf_cnt);
               checkOutput("rf_we_at_resp", {31'd0, rf_we}, (e.rf_cnt > 0) ? 1 : 0);
               checkOutput("busy_cnt",    busy_c,       e.busy_cnt);
            end
         end else if (c > 300) begin
            in_txn = 0;
            checkOutput("resp_timeout", c, 32'd0);
            if (sb.size() > 0) void'(sb.pop_front());
         end
      end
   end

   initial begin : stim
      rst = 1'b1; start = 1'b0; instr_class = 3'd0; mdu_done = 1'b0;
      #12;
      checkOutput("rst_mux",     {29'd0, muxt_alu_a}, 32'd7);
      checkOutput("rst_strobes", {25'd0, ir_we, pc_we, mdu_start, rf_we, busy, done, err}, 32'd0);
      checkOutput("rst_state",   {29'd0, state_o}, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      applyStimulus(0, 0);
      applyStimulus(1, 0);
      applyStimulus(5, 0);
      applyStimulus(3, 0);
      applyStimulus(2, 0);
      applyStimulus(4, 3);
      applyStimulus(4, 1);
      applyStimulus(6, 0);
      applyStimulus(7, 0);
`ifdef ALU_A_SEQ_TIMEOUT_EN
      applyStimulus(4, TO);
      applyStimulus(4, TO + 1);
`else
      applyStimulus(4, 20);
`endif

      // Asynchronous reset in the EXEC cycle of an MDU instruction.
      mon_en = 1'b0;
      @(negedge clk); start = 1'b1; instr_class = 3'd4;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_rst_state", {29'd0, state_o}, 32'd3);
      checkOutput("pre_rst_mdu",   {31'd0, mdu_start}, 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("mid_rst_mux",     {29'd0, muxt_alu_a}, 32'd7);
      checkOutput("mid_rst_strobes", {25'd0, ir_we, pc_we, mdu_start, rf_we, busy, done, err}, 32'd0);
      checkOutput("mid_rst_state",   {29'd0, state_o}, 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      mon_en = 1'b1;
      applyStimulus(0, 0);
      applyStimulus(4, 2);

      for (int n = 0; n < 40; n++) begin
`ifdef ALU_A_SEQ_TIMEOUT_EN
         applyStimulus($urandom_range(0, 7), $urandom_range(1, TO + 2));
`else
         applyStimulus($urandom_range(0, 7), $urandom_range(1, 6));
`endif
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (10) @(negedge clk);
      checkOutput("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
